npc_mem_arbiter: RTL



---
 rtl/npc_mem_arbiter_pkg.sv | 27 ++
 rtl/npc_mem_arbiter_if.sv | 54 +++++
 rtl/npc_mem_arbiter_lane_align.sv | 22 ++
 rtl/npc_mem_arbiter.sv | 110 +++++++++++
 4 files changed

// File: rtl/npc_mem_arbiter_pkg.sv
// Shared widths, FSM state and grant encodings for the memory-side arbiter.
package npc_mem_arbiter_pkg;

  localparam int NPC_ADDR_BUS = 32;
  localparam int XLEN_BUS     = 64;
  localparam int STRB_W       = XLEN_BUS / 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_e;

  // GNT_NONE keeps mem_we_o low out of reset.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DW   = 2'd1,
    GNT_DR   = 2'd2,
    GNT_IR   = 2'd3
  } gnt_e;

  function automatic logic [NPC_ADDR_BUS-1:0] beat_addr(input logic [NPC_ADDR_BUS-1:0] a);
    return {a[NPC_ADDR_BUS-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/npc_mem_arbiter_if.sv
// Client ports (icache read, dcache read/write) and the 64-bit memory port.
interface npc_mem_arbiter_if;
  import npc_mem_arbiter_pkg::*;

  logic [NPC_ADDR_BUS-1:0] ram_raddr_icache_i;
  logic                    ram_raddr_valid_icache_i;
  logic [STRB_W-1:0]       ram_rmask_icache_i;
  logic                    ram_rdata_ready_icache_o;
  logic [XLEN_BUS-1:0]     ram_rdata_icache_o;

  logic [NPC_ADDR_BUS-1:0] ram_raddr_dcache_i;
  logic                    ram_raddr_valid_dcache_i;
  logic [STRB_W-1:0]       ram_rmask_dcache_i;
  logic                    ram_rdata_ready_dcache_o;
  logic [XLEN_BUS-1:0]     ram_rdata_dcache_o;

  logic [NPC_ADDR_BUS-1:0] ram_waddr_dcache_i;
  logic                    ram_waddr_valid_dcache_i;
  logic [STRB_W-1:0]       ram_wmask_dcache_i;
  logic [XLEN_BUS-1:0]     ram_wdata_dcache_i;
  logic                    ram_wdata_ready_dcache_o;

  logic                    mem_req_valid_o;
  logic                    mem_req_ready_i;
  logic                    mem_we_o;
  logic [NPC_ADDR_BUS-1:0] mem_addr_o;
  logic [STRB_W-1:0]       mem_wstrb_o;
  logic [XLEN_BUS-1:0]     mem_wdata_o;
  logic                    mem_resp_valid_i;
  logic [XLEN_BUS-1:0]     mem_rdata_i;

  modport master (
    input  ram_raddr_icache_i, ram_raddr_valid_icache_i, ram_rmask_icache_i,
    output ram_rdata_ready_icache_o, ram_rdata_icache_o,
    input  ram_raddr_dcache_i, ram_raddr_valid_dcache_i, ram_rmask_dcache_i,
    output ram_rdata_ready_dcache_o, ram_rdata_dcache_o,
    input  ram_waddr_dcache_i, ram_waddr_valid_dcache_i, ram_wmask_dcache_i, ram_wdata_dcache_i,
    output ram_wdata_ready_dcache_o,
    output mem_req_valid_o, mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o,
    input  mem_req_ready_i, mem_resp_valid_i, mem_rdata_i
  );

  modport slave (
    output ram_raddr_icache_i, ram_raddr_valid_icache_i, ram_rmask_icache_i,
    input  ram_rdata_ready_icache_o, ram_rdata_icache_o,
    output ram_raddr_dcache_i, ram_raddr_valid_dcache_i, ram_rmask_dcache_i,
    input  ram_rdata_ready_dcache_o, ram_rdata_dcache_o,
    output ram_waddr_dcache_i, ram_waddr_valid_dcache_i, ram_wmask_dcache_i, ram_wdata_dcache_i,
    input  ram_wdata_ready_dcache_o,
    input  mem_req_valid_o, mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o,
    output mem_req_ready_i, mem_resp_valid_i, mem_rdata_i
  );

endinterface

// File: rtl/npc_mem_arbiter_lane_align.sv
// Combinational byte-lane aligner between client-relative and 8-byte-aligned views.
module npc_mem_arbiter_lane_align
  import npc_mem_arbiter_pkg::*;
(
  input  logic [2:0]          off_i,
  input  logic [STRB_W-1:0]   mask_i,
  input  logic [XLEN_BUS-1:0] wdata_i,
  input  logic [XLEN_BUS-1:0] rdata_i,
  output logic [STRB_W-1:0]   wstrb_o,
  output logic [XLEN_BUS-1:0] wdata_o,
  output logic [XLEN_BUS-1:0] rdata_o
);

  logic [5:0] bit_off;

  // Lanes pushed past the top of the beat are silently dropped.
  assign bit_off = {off_i, 3'b000};
  assign wstrb_o = mask_i << off_i;
  assign wdata_o = wdata_i << bit_off;
  assign rdata_o = rdata_i >> bit_off;

endmodule

// File: rtl/npc_mem_arbiter.sv
// Fixed-priority arbiter serialising dcache write/read and icache read onto one memory port.
module npc_mem_arbiter
  import npc_mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  npc_mem_arbiter_if.master bus
);

  arb_state_e              state_q, state_d;
  gnt_e                    gnt_q, gnt_d;
  logic [NPC_ADDR_BUS-1:0] addr_q, addr_d;
  logic [STRB_W-1:0]       mask_q, mask_d;
  logic [XLEN_BUS-1:0]     wdata_q, wdata_d;
  logic [XLEN_BUS-1:0]     rdata_dr_q, rdata_dr_d;
  logic [XLEN_BUS-1:0]     rdata_ir_q, rdata_ir_d;

  logic [STRB_W-1:0]       strb_al;
  logic [XLEN_BUS-1:0]     wdata_al;
  logic [XLEN_BUS-1:0]     rdata_al;

  npc_mem_arbiter_lane_align u_lane_align (
    .off_i   (addr_q[2:0]),
    .mask_i  (mask_q),
    .wdata_i (wdata_q),
    .rdata_i (bus.mem_rdata_i),
    .wstrb_o (strb_al),
    .wdata_o (wdata_al),
    .rdata_o (rdata_al)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    mask_d     = mask_q;
    wdata_d    = wdata_q;
    rdata_dr_d = rdata_dr_q;
    rdata_ir_d = rdata_ir_q;
    case (state_q)
      ARB_IDLE: begin
        if (bus.ram_waddr_valid_dcache_i) begin
          gnt_d   = GNT_DW;
          addr_d  = bus.ram_waddr_dcache_i;
          mask_d  = bus.ram_wmask_dcache_i;
          wdata_d = bus.ram_wdata_dcache_i;
          state_d = ARB_REQ;
        end else if (bus.ram_raddr_valid_dcache_i) begin
          gnt_d   = GNT_DR;
          addr_d  = bus.ram_raddr_dcache_i;
          mask_d  = bus.ram_rmask_dcache_i;
          wdata_d = '0;
          state_d = ARB_REQ;
        end else if (bus.ram_raddr_valid_icache_i) begin
          gnt_d   = GNT_IR;
          addr_d  = bus.ram_raddr_icache_i;
          mask_d  = bus.ram_rmask_icache_i;
          wdata_d = '0;
          state_d = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (bus.mem_req_ready_i) state_d = ARB_RESP;
      end
      ARB_RESP: begin
        // Only the granted reader's register moves; the other keeps its last beat.
        if (bus.mem_resp_valid_i) begin
          if (gnt_q == GNT_DR) rdata_dr_d = rdata_al;
          if (gnt_q == GNT_IR) rdata_ir_d = rdata_al;
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= GNT_NONE;
      addr_q     <= '0;
      mask_q     <= '0;
      wdata_q    <= '0;
      rdata_dr_q <= '0;
      rdata_ir_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      mask_q     <= mask_d;
      wdata_q    <= wdata_d;
      rdata_dr_q <= rdata_dr_d;
      rdata_ir_q <= rdata_ir_d;
    end
  end

  assign bus.mem_req_valid_o = (state_q == ARB_REQ);
  assign bus.mem_we_o        = (gnt_q == GNT_DW);
  assign bus.mem_addr_o      = beat_addr(addr_q);
  assign bus.mem_wstrb_o     = strb_al;
  assign bus.mem_wdata_o     = wdata_al;

  assign bus.ram_wdata_ready_dcache_o = (state_q == ARB_DONE) && (gnt_q == GNT_DW);
  assign bus.ram_rdata_ready_dcache_o = (state_q == ARB_DONE) && (gnt_q == GNT_DR);
  assign bus.ram_rdata_ready_icache_o = (state_q == ARB_DONE) && (gnt_q == GNT_IR);
  assign bus.ram_rdata_dcache_o       = rdata_dr_q;
  assign bus.ram_rdata_icache_o       = rdata_ir_q;

endmodule
